// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: converts pipeline loads/stores into a word-aligned
// req/ack bus transaction, stalls the pipeline meanwhile and formats load data.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        bus_error_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [31:0]       bus_addr_r;
    logic [31:0]       bus_wdata_r;
    logic [3:0]        bus_wstrb_r;
    logic [31:0]       load_data_r;
    logic              bus_error_r;

    logic              op_valid_s;
    logic              is_byte_s;
    logic              is_half_s;
    logic              misalign_raw_s;
    logic              accept_s;
    logic              timeout_s;

    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h00_0000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] format_store(input logic [2:0]  f3,
                                                 input logic [31:0] data);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{data[7:0]}};
            3'b001:  r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [3:0] r;
        case (f3)
            3'b000:  r = 4'b0001 << off;
            3'b001:  r = off[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Access-size decode; code 100/101 only mean byte/half for loads.
    always_comb begin
        op_valid_s     = mem_read_in | mem_write_in;
        is_byte_s      = (funct3_in == 3'b000) | (mem_read_in & (funct3_in == 3'b100));
        is_half_s      = (funct3_in == 3'b001) | (mem_read_in & (funct3_in == 3'b101));
        misalign_raw_s = 1'b0;
        if (is_half_s) begin
            misalign_raw_s = addr_in[0];
        end else if (is_byte_s) begin
            misalign_raw_s = 1'b0;
        end else begin
            misalign_raw_s = (addr_in[1:0] != 2'b00);
        end
        accept_s  = op_valid_s & ~misalign_raw_s & (state_r == ST_IDLE);
        timeout_s = ~bus_ack & (count_r == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_ack || timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM combinational outputs: stall is released only in DONE.
    always_comb begin
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_out      = op_valid_s & ~misalign_raw_s;
                misaligned_out = op_valid_s & misalign_raw_s;
            end
            ST_WAIT: begin
                stall_out      = op_valid_s & ~misalign_raw_s;
                misaligned_out = 1'b0;
            end
            ST_DONE: begin
                stall_out      = 1'b0;
                misaligned_out = 1'b0;
            end
            default: begin
                stall_out      = 1'b0;
                misaligned_out = 1'b0;
            end
        endcase
    end

    // Registered bus request, timeout counter and load-data capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_wstrb_r <= 4'b0000;
            load_data_r <= 32'h0000_0000;
            bus_error_r <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            funct3_r    <= 3'b000;
            offset_r    <= 2'b00;
        end else begin
            bus_error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= mem_write_in;
                        bus_addr_r  <= {addr_in[31:2], 2'b00};
                        bus_wdata_r <= mem_write_in ? format_store(funct3_in, store_data_in)
                                                    : 32'h0000_0000;
                        bus_wstrb_r <= mem_write_in ? store_strobe(funct3_in, addr_in[1:0])
                                                    : 4'b0000;
                        funct3_r    <= funct3_in;
                        offset_r    <= addr_in[1:0];
                        count_r     <= {CNT_W{1'b0}};
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (bus_ack) begin
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            load_data_r <= format_load(funct3_r, offset_r, bus_rdata);
                        end
                    end else if (timeout_s) begin
                        bus_req_r   <= 1'b0;
                        load_data_r <= 32'h0000_0000;
                        bus_error_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    count_r <= {CNT_W{1'b0}};
                end
                default: begin
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req       = bus_req_r;
    assign bus_we        = bus_we_r;
    assign bus_addr      = bus_addr_r;
    assign bus_wdata     = bus_wdata_r;
    assign bus_wstrb     = bus_wstrb_r;
    assign load_data_out = load_data_r;
    assign bus_error_out = bus_error_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout shortened to 4 cycles).
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        misaligned_out;
    logic        bus_error_out;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks;
    int n_fail;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .funct3_in     (funct3_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .stall_out     (stall_out),
        .load_data_out (load_data_out),
        .misaligned_out(misaligned_out),
        .bus_error_out (bus_error_out),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_op();
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        funct3_in     = 3'b000;
        addr_in       = 32'h0;
        store_data_in = 32'h0;
    endtask

    // Load with ack in the first WAIT cycle; checks the DONE-cycle result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        nxt();
        clear_op();
        mem_read_in = 1'b1;
        funct3_in   = f3;
        addr_in     = addr;
        nxt();
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        nxt();
        bus_ack = 1'b0;
        #1;
        chk({tag, "_data"}, load_data_out, exp);
        chk({tag, "_stall_done"}, {31'd0, stall_out}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        clear_op();
        #3;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_load", load_data_out, 32'h0);
        chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_err", {31'd0, bus_error_out}, 32'd0);
        nxt();
        reset_n = 1'b1;

        // lw 0x100, ack in cycle 1
        nxt();
        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        addr_in     = 32'h0000_0100;
        #1;
        chk("lw_stall_c0", {31'd0, stall_out}, 32'd1);
        chk("lw_req_c0", {31'd0, bus_req}, 32'd0);
        chk("lw_mis_c0", {31'd0, misaligned_out}, 32'd0);
        nxt();
        chk("lw_req_c1", {31'd0, bus_req}, 32'd1);
        chk("lw_addr", bus_addr, 32'h0000_0100);
        chk("lw_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("lw_we", {31'd0, bus_we}, 32'd0);
        chk("lw_stall_c1", {31'd0, stall_out}, 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        nxt();
        bus_ack = 1'b0;
        #1;
        chk("lw_stall_c2", {31'd0, stall_out}, 32'd0);
        chk("lw_data", load_data_out, 32'hDEAD_BEEF);
        chk("lw_req_c2", {31'd0, bus_req}, 32'd0);

        do_load("lb", 3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h0000_0202, 32'h8011_2233, 32'h0000_8011);
        do_load("lh", 3'b001, 32'h0000_0200, 32'h1234_8765, 32'hFFFF_8765);

        // sb 0x301, ack lands on the last allowed WAIT cycle (4)
        nxt();
        clear_op();
        mem_write_in  = 1'b1;
        funct3_in     = 3'b000;
        addr_in       = 32'h0000_0301;
        store_data_in = 32'h0000_00AB;
        #1;
        chk("sb_stall_c0", {31'd0, stall_out}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            nxt();
            chk("sb_req_wait", {31'd0, bus_req}, 32'd1);
            chk("sb_stall_wait", {31'd0, stall_out}, 32'd1);
            chk("sb_addr", bus_addr, 32'h0000_0300);
            chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
            chk("sb_wstrb", {28'd0, bus_wstrb}, 32'h0000_0002);
            chk("sb_we", {31'd0, bus_we}, 32'd1);
        end
        nxt();
        chk("sb_req_c4", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1;
        nxt();
        bus_ack = 1'b0;
        #1;
        chk("sb_stall_done", {31'd0, stall_out}, 32'd0);
        chk("sb_no_err", {31'd0, bus_error_out}, 32'd0);
        chk("sb_load_kept", load_data_out, 32'hFFFF_8765);
        chk("sb_req_done", {31'd0, bus_req}, 32'd0);

        // sh 0x302
        nxt();
        clear_op();
        mem_write_in  = 1'b1;
        funct3_in     = 3'b001;
        addr_in       = 32'h0000_0302;
        store_data_in = 32'h1234_CDEF;
        nxt();
        chk("sh_wdata", bus_wdata, 32'hCDEF_CDEF);
        chk("sh_wstrb", {28'd0, bus_wstrb}, 32'h0000_000C);
        bus_ack = 1'b1;
        nxt();
        bus_ack = 1'b0;

        // misaligned lh 0x101 and sw 0x102
        nxt();
        clear_op();
        mem_read_in = 1'b1;
        funct3_in   = 3'b001;
        addr_in     = 32'h0000_0101;
        #1;
        chk("lh_mis", {31'd0, misaligned_out}, 32'd1);
        chk("lh_mis_stall", {31'd0, stall_out}, 32'd0);
        nxt();
        chk("lh_mis_req", {31'd0, bus_req}, 32'd0);
        clear_op();
        mem_write_in = 1'b1;
        funct3_in    = 3'b010;
        addr_in      = 32'h0000_0102;
        #1;
        chk("sw_mis", {31'd0, misaligned_out}, 32'd1);
        chk("sw_mis_stall", {31'd0, stall_out}, 32'd0);
        nxt();
        chk("sw_mis_req", {31'd0, bus_req}, 32'd0);

        // stray ack while idle is ignored
        clear_op();
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        nxt();
        bus_ack = 1'b0;
        #1;
        chk("idle_ack_load", load_data_out, 32'hFFFF_8765);
        chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

        // lw timeout, no ack
        nxt();
        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        addr_in     = 32'h0000_0400;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            chk("to_req_held", {31'd0, bus_req}, 32'd1);
            chk("to_err_low", {31'd0, bus_error_out}, 32'd0);
        end
        nxt();
        chk("to_req_drop", {31'd0, bus_req}, 32'd0);
        chk("to_err_pulse", {31'd0, bus_error_out}, 32'd1);
        chk("to_load_zero", load_data_out, 32'h0);
        chk("to_stall_done", {31'd0, stall_out}, 32'd0);
        nxt();
        clear_op();
        #1;
        chk("to_err_clear", {31'd0, bus_error_out}, 32'd0);
        chk("to_idle_stall", {31'd0, stall_out}, 32'd0);

        // async reset mid-WAIT
        do_load("pre_rst", 3'b010, 32'h0000_0500, 32'hCAFE_F00D, 32'hCAFE_F00D);
        nxt();
        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        addr_in     = 32'h0000_0600;
        nxt();
        chk("rw_req", {31'd0, bus_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_req_drop", {31'd0, bus_req}, 32'd0);
        chk("rw_addr_zero", bus_addr, 32'h0);
        chk("rw_load_zero", load_data_out, 32'h0);
        clear_op();
        nxt();
        reset_n = 1'b1;
        do_load("post_rst", 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678);
        nxt();
        clear_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. Turns a load or store from the pipeline into a word-aligned request/acknowledge transaction on the data bus and stalls the pipeline while the transaction is outstanding. For loads, it extracts, sign- or zero-extends and registers the addressed byte/halfword/word, producing the memory read data that MEM/WB captures.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles without `bus_ack` before the transaction is abandoned (≥1).
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_read_in  input  1  EX/MEM: load in MEM stage.
- mem_write_in  input  1  EX/MEM: store in MEM stage (never both with mem_read_in).
- funct3_in  input  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw; other codes treated as word.
- addr_in  input  32  byte address (ALU result).
- store_data_in  input  32  rs2 value for stores.
- stall_out  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB.
- load_data_out  output  32  formatted load data to MEM/WB.
- misaligned_out  output  1  combinational misaligned-access flag.
- bus_error_out  output  1  one-cycle pulse on timeout.
- bus_req  output  1  transaction request, held until ack.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word address, bits [1:0] always 0.
- bus_wdata  output  32  lane-replicated store data.
- bus_wstrb  output  4  byte enables; 0000 on reads.
- bus_ack  input  1  transaction complete (one cycle).
- bus_rdata  input  32  read word, valid with bus_ack.

## Operation
- Op valid = mem_read_in | mem_write_in. Misaligned = (half access & addr_in[0]) | (word access & addr_in[1:0]≠0).
- FSM states IDLE, WAIT, DONE.
- IDLE: op valid and aligned → register bus_addr={addr_in[31:2],2'b00}, bus_we=mem_write_in, wdata, wstrb, latched funct3/addr[1:0]; bus_req=1 next cycle; → WAIT. Op valid and misaligned → misaligned_out=1, no transaction, no stall, stay IDLE.
- WAIT: bus_req held with all bus outputs stable. bus_ack → bus_req=0; for reads, load_data_out ← formatted bus_rdata; → DONE. Counter reaches TIMEOUT_CYCLES without ack → bus_req=0, load_data_out=0, bus_error_out=1 for one cycle; → DONE. Ack on the timeout cycle wins (normal completion, no error).
- DONE: stall_out=0 for exactly this cycle so the pipeline advances; → IDLE unconditionally.
- stall_out = op valid & aligned & (state IDLE or WAIT); 0 in DONE.
- Load format (latched addr[1:0]): byte = rdata[8·a+7:8·a]; half = rdata[16·a[1]+15:16·a[1]]; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
- Store: sb wdata={4{b}}, wstrb=0001<<a; sh wdata={2{h}}, wstrb=0011<<(2·a[1]); sw wstrb=1111.
- Stores leave load_data_out unchanged. bus_ack in IDLE or DONE is ignored.
- Reset (async, any state including WAIT): state IDLE, bus_req/bus_we/bus_error_out 0, bus_addr/bus_wdata/load_data_out 0, bus_wstrb 0000, counter 0; bus_req drops immediately.

## Timing
- Op presented cycle 0 (IDLE) → bus_req high cycle 1. Ack in cycle k≥1 → DONE cycle k+1, load_data_out valid and stall_out low in k+1, captured by MEM/WB at end of k+1.
- Minimum 3 cycles per memory op (ack in cycle 1); back-to-back ops restart from IDLE.
- Timeout: counter increments each WAIT cycle without ack; bus_error_out pulses in the DONE cycle.
- misaligned_out is combinational from inputs, valid in cycle 0 only while in IDLE.

## Test plan
- lw addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF → bus_addr 0x100, wstrb 0000, stall cycles 0–1, load_data_out 0xDEADBEEF in cycle 2.
- lb addr 0x203, rdata 0x80112233 → load_data_out 0xFFFFFF80; lbu same → 0x00000080; lhu addr 0x202 → 0x00008011.
- sb addr 0x301 data 0x000000AB, ack after 3 WAIT cycles → bus_we 1, wdata 0xABABABAB, wstrb 0010, stall low only in DONE.
- lh addr 0x101 and sw addr 0x102 → misaligned_out 1, bus_req never asserted, stall_out 0.
- TIMEOUT_CYCLES=4, lw with no ack → bus_req high 4 cycles then low, bus_error_out one-cycle pulse, load_data_out 0, return to IDLE.
- reset_n low mid-WAIT → bus_req 0 and all outputs zero immediately; after release, new lw completes normally.
